// File: rtl/txll_defs.sv
// Bit positions of the sideband flags shared by the TX link-layer blocks.
package txll_defs;
   localparam int TXLL_SOF_BIT = 35;
   localparam int TXLL_EOF_BIT = 34;
endpackage

// File: rtl/txll_fifo_ram.sv
// Frame FIFO storage: one synchronous write port, one asynchronous read port.
module txll_fifo_ram #(
   parameter int DW = 36,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/txll_frame_fifo.sv
// Frame-aware FWFT FIFO: store-and-forward (commit on EOF, abortable) or cut-through.
module txll_frame_fifo
   import txll_defs::*;
#(
   parameter int C_DATA_WIDTH    = 36,
   parameter int C_ADDR_WIDTH    = 9,
   parameter int C_EOF_BIT       = TXLL_EOF_BIT,
   parameter int C_AFULL_THRESH  = 256,
   parameter int C_AEMPTY_THRESH = 4,
   parameter int C_PACKET_MODE   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [C_DATA_WIDTH-1:0] wr_di,
   input  logic                    wr_en,
   input  logic                    wr_abort,
   output logic                    wr_full,
   output logic                    wr_almost_full,
   output logic [C_ADDR_WIDTH:0]   wr_count,
   output logic                    wr_err,
   output logic                    wr_eof_poped,
   output logic [C_DATA_WIDTH-1:0] rd_do,
   input  logic                    rd_en,
   output logic                    rd_empty,
   output logic                    rd_almost_empty,
   output logic [C_ADDR_WIDTH:0]   rd_count,
   output logic                    rd_err,
   output logic                    rd_eof_rdy,
   output logic [C_ADDR_WIDTH:0]   frame_count
);
   localparam int                  DEPTH     = 1 << C_ADDR_WIDTH;
   localparam logic [C_ADDR_WIDTH:0] DEPTH_C  = DEPTH[C_ADDR_WIDTH:0];
   localparam logic [C_ADDR_WIDTH:0] AFULL_C  = C_AFULL_THRESH[C_ADDR_WIDTH:0];
   localparam logic [C_ADDR_WIDTH:0] AEMPTY_C = C_AEMPTY_THRESH[C_ADDR_WIDTH:0];
   localparam logic [C_ADDR_WIDTH:0] ONE_C    = {{C_ADDR_WIDTH{1'b0}}, 1'b1};

   // Pointers carry one extra bit so a full FIFO is distinguishable from empty.
   logic [C_ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
   logic [C_ADDR_WIDTH:0] commit_ptr_q, commit_ptr_d;
   logic [C_ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
   logic [C_ADDR_WIDTH:0] frame_count_q, frame_count_d;
   logic                  wr_err_q, wr_err_d;
   logic                  rd_err_q, rd_err_d;
   logic                  eof_poped_q, eof_poped_d;

   logic abort_eff, push, commit, pop, eof_pop;
   logic [C_ADDR_WIDTH:0] readable_ptr;

   assign abort_eff    = wr_abort && (C_PACKET_MODE != 0);
   assign readable_ptr = (C_PACKET_MODE != 0) ? commit_ptr_q : wr_ptr_q;
   assign wr_count     = wr_ptr_q - rd_ptr_q;
   assign rd_count     = readable_ptr - rd_ptr_q;
   assign wr_full      = (wr_count == DEPTH_C);
   assign rd_empty     = (rd_count == '0);
   assign push         = wr_en && !wr_full && !abort_eff;
   assign commit       = push && wr_di[C_EOF_BIT];
   assign pop          = rd_en && !rd_empty;
   assign eof_pop      = pop && rd_do[C_EOF_BIT];

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      if (abort_eff) wr_ptr_d = commit_ptr_q;
      else if (push) wr_ptr_d = wr_ptr_q + ONE_C;
      if (commit)    commit_ptr_d = wr_ptr_q + ONE_C;
      if (pop)       rd_ptr_d = rd_ptr_q + ONE_C;
      frame_count_d = frame_count_q + {{C_ADDR_WIDTH{1'b0}}, commit}
                                    - {{C_ADDR_WIDTH{1'b0}}, eof_pop};
      wr_err_d     = wr_en && wr_full && !abort_eff;
      rd_err_d     = rd_en && rd_empty;
      eof_poped_d  = eof_pop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         commit_ptr_q  <= '0;
         rd_ptr_q      <= '0;
         frame_count_q <= '0;
         wr_err_q      <= 1'b0;
         rd_err_q      <= 1'b0;
         eof_poped_q   <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         commit_ptr_q  <= commit_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         frame_count_q <= frame_count_d;
         wr_err_q      <= wr_err_d;
         rd_err_q      <= rd_err_d;
         eof_poped_q   <= eof_poped_d;
      end
   end

   assign wr_almost_full  = (wr_count >= AFULL_C);
   assign rd_almost_empty = (rd_count <= AEMPTY_C);
   assign rd_eof_rdy      = (frame_count_q != '0);
   assign frame_count     = frame_count_q;
   assign wr_err          = wr_err_q;
   assign rd_err          = rd_err_q;
   assign wr_eof_poped    = eof_poped_q;

   txll_fifo_ram #(
      .DW (C_DATA_WIDTH),
      .AW (C_ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q[C_ADDR_WIDTH-1:0]),
      .wdata (wr_di),
      .raddr (rd_ptr_q[C_ADDR_WIDTH-1:0]),
      .rdata (rd_do)
   );
endmodule

// File: tb/tb_txll_frame_fifo.sv
// Bench for txll_frame_fifo: one packet-mode and one cut-through instance, default geometry.
module tb_txll_frame_fifo;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [35:0] p_wr_di, p_rd_do, c_wr_di, c_rd_do;
   logic p_wr_en, p_wr_abort, p_rd_en, c_wr_en, c_wr_abort, c_rd_en;
   logic p_wr_full, p_wr_afull, p_wr_err, p_eofp, p_rd_empty, p_rd_aempty, p_rd_err, p_eof_rdy;
   logic c_wr_full, c_wr_afull, c_wr_err, c_eofp, c_rd_empty, c_rd_aempty, c_rd_err, c_eof_rdy;
   logic [9:0] p_wr_count, p_rd_count, p_frame_count, c_wr_count, c_rd_count, c_frame_count;

   txll_frame_fifo #(.C_PACKET_MODE(1)) u_pkt (
      .clk(clk), .rst(rst), .wr_di(p_wr_di), .wr_en(p_wr_en), .wr_abort(p_wr_abort),
      .wr_full(p_wr_full), .wr_almost_full(p_wr_afull), .wr_count(p_wr_count),
      .wr_err(p_wr_err), .wr_eof_poped(p_eofp), .rd_do(p_rd_do), .rd_en(p_rd_en),
      .rd_empty(p_rd_empty), .rd_almost_empty(p_rd_aempty), .rd_count(p_rd_count),
      .rd_err(p_rd_err), .rd_eof_rdy(p_eof_rdy), .frame_count(p_frame_count));

   txll_frame_fifo #(.C_PACKET_MODE(0)) u_ct (
      .clk(clk), .rst(rst), .wr_di(c_wr_di), .wr_en(c_wr_en), .wr_abort(c_wr_abort),
      .wr_full(c_wr_full), .wr_almost_full(c_wr_afull), .wr_count(c_wr_count),
      .wr_err(c_wr_err), .wr_eof_poped(c_eofp), .rd_do(c_rd_do), .rd_en(c_rd_en),
      .rd_empty(c_rd_empty), .rd_almost_empty(c_rd_aempty), .rd_count(c_rd_count),
      .rd_err(c_rd_err), .rd_eof_rdy(c_eof_rdy), .frame_count(c_frame_count));

   int total = 0;
   int bad   = 0;
   logic [35:0] q_rd[$];
   logic [35:0] q_pend[$];
   logic [35:0] q_ct[$];

   typedef struct {
      logic wr, ab, eof, rd;
      logic [9:0] wc, rc, fc;
      logic emp, werr, rerr, eofp;
   } vec_t;
   vec_t tv[9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [35:0] mk_word(input logic eof);
      logic [35:0] d;
      d = '0;
      d[31:0] = $urandom;
      d[34] = eof;
      return d;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One packet-mode cycle; scoreboard compares the FWFT word on a pop.
   task automatic pkt_op(input logic wr, input logic ab, input logic eof, input logic rd);
      logic [35:0] d;
      d = mk_word(eof);
      p_wr_di = d; p_wr_en = wr; p_wr_abort = ab; p_rd_en = rd;
      if (rd && q_rd.size() > 0) chk("p_rd_do", p_rd_do, q_rd.pop_front());
      if (ab) q_pend.delete();
      else if (wr) begin
         q_pend.push_back(d);
         if (eof) begin
            foreach (q_pend[i]) q_rd.push_back(q_pend[i]);
            q_pend.delete();
         end
      end
      step();
      p_wr_en = 1'b0; p_wr_abort = 1'b0; p_rd_en = 1'b0;
   endtask

   task automatic ct_op(input logic wr, input logic ab, input logic rd);
      logic [35:0] d;
      d = mk_word(1'b0);
      c_wr_di = d; c_wr_en = wr; c_wr_abort = ab; c_rd_en = rd;
      if (rd && q_ct.size() > 0) chk("c_rd_do", c_rd_do, q_ct.pop_front());
      if (wr && q_ct.size() < 512) q_ct.push_back(d);
      step();
      c_wr_en = 1'b0; c_wr_abort = 1'b0; c_rd_en = 1'b0;
   endtask

   task automatic chk_pkt(input string nm, input logic [9:0] wc, input logic [9:0] rc,
                          input logic [9:0] fc, input logic emp);
      chk({nm, ".wr_count"}, p_wr_count, wc);
      chk({nm, ".rd_count"}, p_rd_count, rc);
      chk({nm, ".frame_count"}, p_frame_count, fc);
      chk({nm, ".rd_empty"}, p_rd_empty, emp);
      chk({nm, ".rd_eof_rdy"}, p_eof_rdy, fc != 0);
   endtask

   initial begin
      //        wr ab eof rd  wc rc fc emp werr rerr eofp
      tv[0] = '{0, 0, 0, 1,  0, 0, 0, 1,  0,   1,   0};
      tv[1] = '{1, 0, 0, 0,  1, 0, 0, 1,  0,   0,   0};
      tv[2] = '{1, 0, 0, 0,  2, 0, 0, 1,  0,   0,   0};
      tv[3] = '{1, 0, 1, 0,  3, 3, 1, 0,  0,   0,   0};
      tv[4] = '{1, 0, 0, 1,  3, 2, 1, 0,  0,   0,   0};
      tv[5] = '{1, 1, 0, 0,  2, 2, 1, 0,  0,   0,   0};
      tv[6] = '{0, 0, 0, 1,  1, 1, 1, 0,  0,   0,   0};
      tv[7] = '{0, 0, 0, 1,  0, 0, 0, 1,  0,   0,   1};
      tv[8] = '{0, 0, 0, 1,  0, 0, 0, 1,  0,   1,   0};

      rst = 1'b1;
      p_wr_di = '0; p_wr_en = 0; p_wr_abort = 0; p_rd_en = 0;
      c_wr_di = '0; c_wr_en = 0; c_wr_abort = 0; c_rd_en = 0;
      repeat (3) step();
      chk_pkt("rst", 0, 0, 0, 1);
      chk("rst.p_aempty", p_rd_aempty, 1);
      chk("rst.p_full", p_wr_full, 0);
      chk("rst.p_afull", p_wr_afull, 0);
      chk("rst.pulses", {p_wr_err, p_rd_err, p_eofp}, 0);
      chk("rst.c_empty", c_rd_empty, 1);
      chk("rst.c_count", c_wr_count, 0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 9; i++) begin
         pkt_op(tv[i].wr, tv[i].ab, tv[i].eof, tv[i].rd);
         chk_pkt($sformatf("vec%0d", i), tv[i].wc, tv[i].rc, tv[i].fc, tv[i].emp);
         chk($sformatf("vec%0d.wr_err", i), p_wr_err, tv[i].werr);
         chk($sformatf("vec%0d.rd_err", i), p_rd_err, tv[i].rerr);
         chk($sformatf("vec%0d.eof_poped", i), p_eofp, tv[i].eofp);
      end

      // 3-word frame: nothing readable until the EOF word lands
      pkt_op(1, 0, 0, 0);
      pkt_op(1, 0, 0, 0);
      chk_pkt("f3.w2", 2, 0, 0, 1);
      pkt_op(1, 0, 1, 0);
      chk_pkt("f3.w3", 3, 3, 1, 0);
      repeat (3) pkt_op(0, 0, 0, 1);
      chk_pkt("f3.drained", 0, 0, 0, 1);

      // abort of a 5-word partial frame, then an intact frame
      repeat (5) pkt_op(1, 0, 0, 0);
      chk_pkt("abort.before", 5, 0, 0, 1);
      pkt_op(0, 1, 0, 0);
      chk_pkt("abort.after", 0, 0, 0, 1);
      chk("abort.wr_err", p_wr_err, 0);
      pkt_op(1, 0, 0, 0);
      pkt_op(1, 0, 1, 0);
      chk_pkt("abort.next", 2, 2, 1, 0);
      pkt_op(0, 0, 0, 1);
      pkt_op(0, 0, 0, 1);
      chk_pkt("abort.read", 0, 0, 0, 1);

      // EOF pop coinciding with an EOF commit
      pkt_op(1, 0, 1, 0);
      chk_pkt("cpop.pre", 1, 1, 1, 0);
      pkt_op(1, 0, 1, 1);
      chk_pkt("cpop.same", 1, 1, 1, 0);
      chk("cpop.eofp1", p_eofp, 1);
      pkt_op(0, 0, 0, 0);
      chk("cpop.eofp2", p_eofp, 0);
      pkt_op(0, 0, 0, 1);
      chk_pkt("cpop.end", 0, 0, 0, 1);
      chk("cpop.eofp3", p_eofp, 1);

      // reset with two complete frames buffered
      repeat (2) begin
         pkt_op(1, 0, 0, 0);
         pkt_op(1, 0, 1, 0);
      end
      chk_pkt("rst2.pre", 4, 4, 2, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      q_rd.delete(); q_pend.delete();
      chk_pkt("rst2.post", 0, 0, 0, 1);
      pkt_op(1, 0, 1, 0);
      pkt_op(0, 0, 0, 1);
      chk_pkt("rst2.reuse", 0, 0, 0, 1);

      // cut-through: readable immediately, abort ignored
      ct_op(1, 1, 0);
      chk("ct.first.count", c_wr_count, 1);
      chk("ct.first.empty", c_rd_empty, 0);
      chk("ct.first.wr_err", c_wr_err, 0);
      for (int k = 2; k <= 512; k++) begin
         ct_op(1, 0, 0);
         if (k == 255) chk("ct.afull255", c_wr_afull, 0);
         if (k == 256) chk("ct.afull256", c_wr_afull, 1);
         if (k == 511) chk("ct.full511", c_wr_full, 0);
      end
      chk("ct.full512", c_wr_full, 1);
      chk("ct.count512", c_wr_count, 512);
      ct_op(1, 0, 0);
      chk("ct.ovf.wr_err", c_wr_err, 1);
      chk("ct.ovf.count", c_wr_count, 512);
      ct_op(0, 0, 0);
      chk("ct.ovf.wr_err_clr", c_wr_err, 0);
      for (int k = 512; k > 0; k--) begin
         chk("ct.aempty", c_rd_aempty, k <= 4);
         ct_op(0, 0, 1);
      end
      chk("ct.drained.empty", c_rd_empty, 1);
      chk("ct.drained.count", c_rd_count, 0);
      ct_op(0, 0, 1);
      chk("ct.rd_err", c_rd_err, 1);
      chk("ct.rd_err.count", c_wr_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/txll_frame_fifo.md
TXLL_FRAME_FIFO -- requirements
Module: txll_frame_fifo

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 36, word width including sideband bits.
REQ-002 SHALL have parameter C_ADDR_WIDTH, default 9, log2 of depth (512 words).
REQ-003 SHALL have parameter C_EOF_BIT, default 34, bit index of end-of-frame flag in wr_di.
REQ-004 SHALL have parameter C_AFULL_THRESH, default 256, almost-full level in words.
REQ-005 SHALL have parameter C_AEMPTY_THRESH, default 4, almost-empty level in words.
REQ-006 SHALL have parameter C_PACKET_MODE, default 1: 1 = store-and-forward, 0 = cut-through.
REQ-007 One clock; reset is synchronous and active-high: clk input 1, sole clock, all logic on rising edge.
REQ-008 rst input 1, synchronous active-high reset.
REQ-009 wr_di input C_DATA_WIDTH, write data.
REQ-010 wr_en input 1, write strobe.
REQ-011 wr_abort input 1, discard current uncommitted frame.
REQ-012 wr_full output 1; wr_almost_full output 1; wr_count output C_ADDR_WIDTH+1, words held incl. uncommitted.
REQ-013 wr_err output 1, one-cycle pulse on rejected write.
REQ-014 wr_eof_poped output 1, one-cycle pulse after an EOF word is read.
REQ-015 rd_do output C_DATA_WIDTH, first-word-fall-through data.
REQ-016 rd_en input 1, pop strobe.
REQ-017 rd_empty output 1; rd_almost_empty output 1; rd_count output C_ADDR_WIDTH+1, words readable.
REQ-018 rd_err output 1, one-cycle pulse on rejected read.
REQ-019 rd_eof_rdy output 1, at least one complete frame buffered; frame_count output C_ADDR_WIDTH+1, complete frames buffered.

Function
REQ-020 Write accepted when wr_en && !wr_full && !wr_abort; wr_en && wr_full drops word, pulses wr_err next cycle.
REQ-021 Write pointer wraps modulo 2^C_ADDR_WIDTH; wr_full = (wr_count == 2^C_ADDR_WIDTH).
REQ-022 Accepted word with wr_di[C_EOF_BIT]=1 commits the frame: commit pointer := write pointer+1, frame_count += 1.
REQ-023 Packet mode: readable words = committed words only; cut-through: readable = all written words.
REQ-024 Readable word written/committed at edge N SHALL make rd_empty low and rd_do valid after edge N (one-cycle latency).
REQ-025 Pop accepted when rd_en && !rd_empty; rd_do advances to next word after the same edge; rd_en && rd_empty ignored, pulses rd_err.
REQ-026 Popping a word with EOF set SHALL decrement frame_count and pulse wr_eof_poped next cycle.
REQ-027 Simultaneous commit and EOF pop SHALL leave frame_count unchanged; simultaneous push and pop leave counts unchanged.
REQ-028 wr_abort (packet mode): write pointer := commit pointer, wr_count drops by uncommitted words, any same-cycle wr_en word discarded; abort wins.
REQ-029 wr_abort in cut-through mode SHALL be ignored, no error.
REQ-030 rd_eof_rdy = (frame_count != 0); wr_almost_full = (wr_count >= C_AFULL_THRESH); rd_almost_empty = (rd_count <= C_AEMPTY_THRESH).
REQ-031 Frame longer than depth in packet mode: words beyond full dropped with wr_err; only wr_abort recovers.

Reset
REQ-032 During rst: pointers, counts, frame_count zero; rd_empty=1, rd_almost_empty=1, wr_full=0, wr_almost_full=0 (if threshold>0), rd_eof_rdy=0, all pulses 0.
REQ-033 rst mid-frame SHALL discard all contents including partial frames; memory array contents need not be cleared.

Structure
REQ-034 Shared header txll_defs SHALL hold EOF/SOF bit index constants used by all TX link-layer blocks.
REQ-035 Storage SHALL be sub-module txll_fifo_ram: single-clock, one write port, one asynchronous/prefetched read port.

Verification
REQ-036 Packet mode: write 3 words, EOF on third -> rd_empty=1 until cycle after third write, then rd_count=3, frame_count=1, rd_eof_rdy=1.
REQ-037 Packet mode: write 5 words no EOF, assert wr_abort -> wr_count 5->0 next cycle, rd_empty stays 1, next frame reads intact.
REQ-038 Fill 512 words in cut-through -> wr_full=1, 513th write pulses wr_err, wr_count stays 512; wr_almost_full high from count 256.
REQ-039 Pop EOF word while another EOF word is written same cycle -> frame_count unchanged, wr_eof_poped pulses once.
REQ-040 rd_en on empty FIFO -> rd_err pulse, pointers unchanged; rst asserted with 2 frames buffered -> all counts 0 next cycle.
